// File: rtl/coeff_data_feeder.sv
// coeff_data_feeder
// Holds the r_j table, the signed coefficient-index table and a circular
// sample history. For every accepted input sample it restarts the
// accumulate/shift engine and then answers its readyForData /
// requestNextEndCoeff strobes with the next x(n-k) sample, the coefficient
// sign and the running end-of-stage coefficient index.
//
// All tables are arrays with registered reads. The coefficient and r_j
// read ports always look one entry ahead of the entry currently presented,
// so a strobe on every cycle can be answered on the very next edge.
module coeff_data_feeder #(
    parameter int RJ_SIZE     = 16,
    parameter int COEFF_DEPTH = 512,
    parameter int DATA_DEPTH  = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rjWrEn,
    input  logic [$clog2(RJ_SIZE)-1:0]      rjWrAddr,
    input  logic [15:0]                     rjWrData,
    input  logic                            coeffWrEn,
    input  logic [$clog2(COEFF_DEPTH)-1:0]  coeffWrAddr,
    input  logic [$clog2(DATA_DEPTH):0]     coeffWrData,
    input  logic                            sampleValid,
    input  logic [15:0]                     sampleIn,
    input  logic                            readyForData,
    input  logic                            requestNextEndCoeff,
    input  logic                            thisNCompleted,
    output logic                            calcResetN,
    output logic [15:0]                     inData,
    output logic                            inCoeffSign,
    output logic [15:0]                     rjIn,
    output logic [9:0]                      endCoeffIndex,
    output logic                            busy,
    output logic                            frameDone,
    output logic                            overrun
);

    localparam int RJ_AW    = $clog2(RJ_SIZE);
    localparam int COEFF_AW = $clog2(COEFF_DEPTH);
    localparam int DATA_AW  = $clog2(DATA_DEPTH);

    localparam logic [RJ_AW-1:0]    RJ_LAST    = RJ_AW'(RJ_SIZE - 1);
    localparam logic [COEFF_AW-1:0] COEFF_LAST = COEFF_AW'(COEFF_DEPTH - 1);
    localparam logic [DATA_AW:0]    FILL_FULL  = (DATA_AW + 1)'(DATA_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_FEED,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_AW-1:0]  wr_ptr_reg;
    logic [DATA_AW-1:0]  cur_ptr_reg;
    logic [DATA_AW:0]    fill_reg;
    logic [COEFF_AW-1:0] coeff_ptr_reg, coeff_ptr_next;
    logic [RJ_AW-1:0]    j_reg, j_next;
    logic                overrun_reg;

    logic                take_sample;
    logic                load_pair;
    logic                adv_stage;
    logic [COEFF_AW-1:0] coeff_rd_addr;
    logic [RJ_AW-1:0]    rj_rd_addr;

    // Table storage and their registered read ports
    logic [15:0]        rj_mem    [RJ_SIZE];
    logic [DATA_AW:0]   coeff_mem [COEFF_DEPTH];
    logic [15:0]        hist_mem  [DATA_DEPTH];
    logic [15:0]        rj_q;
    logic [DATA_AW:0]   coeff_q;
    logic [15:0]        hist_q;

    logic [DATA_AW-1:0] hist_rd_addr;
    logic               k_in_range;

    logic               in_mask_reg;
    logic               in_sign_reg;
    logic [15:0]        rj_in_reg;
    logic [9:0]         end_idx_reg;

    // Next-state, pointer advance and look-ahead read addresses
    always_comb begin
        state_next     = state_reg;
        coeff_ptr_next = coeff_ptr_reg;
        j_next         = j_reg;
        take_sample    = 1'b0;
        load_pair      = 1'b0;
        adv_stage      = 1'b0;
        coeff_rd_addr  = '0;
        rj_rd_addr     = '0;

        case (state_reg)
            S_IDLE: begin
                // Read ports sit on entry 0 so RESTART sees coeff[0] and r_1.
                if (sampleValid) begin
                    take_sample    = 1'b1;
                    coeff_ptr_next = '0;
                    j_next         = '0;
                    state_next     = S_RESTART;
                end
            end
            S_RESTART: begin
                // Present entry 0 / stage 0 on this edge, fetch entry 1 ahead.
                load_pair     = 1'b1;
                coeff_rd_addr = COEFF_AW'(1);
                rj_rd_addr    = RJ_AW'(1);
                state_next    = S_FEED;
            end
            S_FEED: begin
                if (readyForData) begin
                    load_pair = 1'b1;
                    if (coeff_ptr_reg != COEFF_LAST) begin
                        coeff_ptr_next = coeff_ptr_reg + COEFF_AW'(1);
                    end
                end
                if (requestNextEndCoeff) begin
                    if (j_reg == RJ_LAST) begin
                        state_next = S_WAIT_DONE;
                    end else begin
                        adv_stage = 1'b1;
                        j_next    = j_reg + RJ_AW'(1);
                    end
                end
                coeff_rd_addr = (coeff_ptr_next == COEFF_LAST) ? COEFF_LAST
                                                               : coeff_ptr_next + COEFF_AW'(1);
                rj_rd_addr    = (j_next == RJ_LAST) ? RJ_LAST : j_next + RJ_AW'(1);
            end
            S_WAIT_DONE: begin
                if (thisNCompleted) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // History address for the look-ahead coefficient; samples older than the
    // history fill level read as zero.
    always_comb begin
        hist_rd_addr = cur_ptr_reg - coeff_q[DATA_AW-1:0];
        k_in_range   = ({1'b0, coeff_q[DATA_AW-1:0]} < fill_reg);
    end

    // Control state, history pointers and sticky overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            cur_ptr_reg   <= '0;
            fill_reg      <= '0;
            coeff_ptr_reg <= '0;
            j_reg         <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            coeff_ptr_reg <= coeff_ptr_next;
            j_reg         <= j_next;
            if (take_sample) begin
                cur_ptr_reg <= wr_ptr_reg;
                wr_ptr_reg  <= wr_ptr_reg + DATA_AW'(1);
                if (fill_reg != FILL_FULL) begin
                    fill_reg <= fill_reg + (DATA_AW + 1)'(1);
                end
            end
            if (sampleValid && (state_reg != S_IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // r_j table: writes only while idle, look-ahead registered read
    always_ff @(posedge clk) begin
        if (rjWrEn && (state_reg == S_IDLE)) begin
            rj_mem[rjWrAddr] <= rjWrData;
        end
        rj_q <= rj_mem[rj_rd_addr];
    end

    // Coefficient table: writes only while idle, look-ahead registered read
    always_ff @(posedge clk) begin
        if (coeffWrEn && (state_reg == S_IDLE)) begin
            coeff_mem[coeffWrAddr] <= coeffWrData;
        end
        coeff_q <= coeff_mem[coeff_rd_addr];
    end

    // Sample history: circular write of new samples, registered read of x(n-k)
    always_ff @(posedge clk) begin
        if (take_sample) begin
            hist_mem[wr_ptr_reg] <= sampleIn;
        end
        if (load_pair) begin
            hist_q <= hist_mem[hist_rd_addr];
        end
    end

    // Presented pair qualifiers and stage bookkeeping outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            in_mask_reg <= 1'b0;
            in_sign_reg <= 1'b0;
            rj_in_reg   <= '0;
            end_idx_reg <= '0;
        end else begin
            if (load_pair) begin
                in_mask_reg <= k_in_range;
                in_sign_reg <= coeff_q[DATA_AW];
            end
            if (state_reg == S_RESTART) begin
                rj_in_reg   <= rj_q;
                end_idx_reg <= rj_q[9:0];
            end else if (adv_stage) begin
                rj_in_reg   <= rj_q;
                end_idx_reg <= end_idx_reg + rj_q[9:0];
            end
        end
    end

    assign calcResetN    = (state_reg != S_RESTART);
    assign busy          = (state_reg != S_IDLE);
    assign frameDone     = (state_reg == S_DONE);
    assign overrun       = overrun_reg;
    assign inData        = in_mask_reg ? hist_q : 16'h0000;
    assign inCoeffSign   = in_sign_reg;
    assign rjIn          = rj_in_reg;
    assign endCoeffIndex = end_idx_reg;

endmodule

// File: tb/tb_coeff_data_feeder.sv
// Directed testbench for coeff_data_feeder: hand-computed expectations,
// one line printed per completed frame.
module tb_coeff_data_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rjWrEn;
    logic [3:0]  rjWrAddr;
    logic [15:0] rjWrData;
    logic        coeffWrEn;
    logic [8:0]  coeffWrAddr;
    logic [8:0]  coeffWrData;
    logic        sampleValid;
    logic [15:0] sampleIn;
    logic        readyForData;
    logic        requestNextEndCoeff;
    logic        thisNCompleted;
    logic        calcResetN;
    logic [15:0] inData;
    logic        inCoeffSign;
    logic [15:0] rjIn;
    logic [9:0]  endCoeffIndex;
    logic        busy;
    logic        frameDone;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;

    coeff_data_feeder dut (
        .clk                 (clk),
        .reset               (reset),
        .rjWrEn              (rjWrEn),
        .rjWrAddr            (rjWrAddr),
        .rjWrData            (rjWrData),
        .coeffWrEn           (coeffWrEn),
        .coeffWrAddr         (coeffWrAddr),
        .coeffWrData         (coeffWrData),
        .sampleValid         (sampleValid),
        .sampleIn            (sampleIn),
        .readyForData        (readyForData),
        .requestNextEndCoeff (requestNextEndCoeff),
        .thisNCompleted      (thisNCompleted),
        .calcResetN          (calcResetN),
        .inData              (inData),
        .inCoeffSign         (inCoeffSign),
        .rjIn                (rjIn),
        .endCoeffIndex       (endCoeffIndex),
        .busy                (busy),
        .frameDone           (frameDone),
        .overrun             (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wr_rj(input logic [3:0] a, input logic [15:0] d);
        rjWrEn = 1'b1; rjWrAddr = a; rjWrData = d;
        tick();
        rjWrEn = 1'b0;
    endtask

    task automatic wr_coeff(input logic [8:0] a, input logic [8:0] d);
        coeffWrEn = 1'b1; coeffWrAddr = a; coeffWrData = d;
        tick();
        coeffWrEn = 1'b0;
    endtask

    // Sample strobe, one RESTART cycle, returns with the DUT in FEED.
    task automatic send_sample(input logic [15:0] s);
        sampleValid = 1'b1; sampleIn = s;
        tick();
        sampleValid = 1'b0;
        check("restart_calcResetN", calcResetN, 1'b0);
        check("restart_busy", busy, 1'b1);
        tick();
        check("feed_calcResetN", calcResetN, 1'b1);
    endtask

    task automatic strobe(input logic rdy, input logic req);
        readyForData = rdy; requestNextEndCoeff = req;
        tick();
        readyForData = 1'b0; requestNextEndCoeff = 1'b0;
    endtask

    // Issue the remaining stage requests, then complete the frame.
    task automatic finish_frame(input int reqs);
        for (int i = 0; i < reqs; i++) strobe(1'b0, 1'b1);
        check("wait_busy", busy, 1'b1);
        check("wait_no_done", frameDone, 1'b0);
        thisNCompleted = 1'b1;
        tick();
        thisNCompleted = 1'b0;
        check("done_pulse", frameDone, 1'b1);
        tick();
        check("idle_done_low", frameDone, 1'b0);
        check("idle_busy_low", busy, 1'b0);
        n_frames++;
        $display("frame %0d complete endCoeffIndex=%0d overrun=%0b", n_frames, endCoeffIndex, overrun);
    endtask

    initial begin
        reset = 1'b1;
        rjWrEn = 1'b0; rjWrAddr = '0; rjWrData = '0;
        coeffWrEn = 1'b0; coeffWrAddr = '0; coeffWrData = '0;
        sampleValid = 1'b0; sampleIn = '0;
        readyForData = 1'b0; requestNextEndCoeff = 1'b0; thisNCompleted = 1'b0;
        tick();
        tick();
        check("rst_calcResetN", calcResetN, 1'b1);
        check("rst_inData", inData, 16'h0);
        check("rst_sign", inCoeffSign, 1'b0);
        check("rst_rjIn", rjIn, 16'h0);
        check("rst_endIdx", endCoeffIndex, 10'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frameDone", frameDone, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;

        // r_j = 1, all coefficients {+, k=0}: every strobe returns the sample
        for (int i = 0; i < 16; i++) wr_rj(4'(i), 16'd1);
        for (int i = 0; i < 16; i++) wr_coeff(9'(i), 9'h000);
        send_sample(16'h1234);
        check("t1_inData0", inData, 16'h1234);
        check("t1_sign0", inCoeffSign, 1'b0);
        check("t1_endIdx0", endCoeffIndex, 10'd1);
        check("t1_rjIn0", rjIn, 16'd1);
        for (int i = 1; i < 16; i++) begin
            strobe(1'b1, 1'b1);
            check("t1_inData", inData, 16'h1234);
            check("t1_endIdx", endCoeffIndex, 10'(i + 1));
        end
        finish_frame(1);
        check("t1_endIdx_hold", endCoeffIndex, 10'd16);

        // coeff[0] = {-, k=3}: zero until the history holds four samples
        apply_reset();
        wr_coeff(9'd0, 9'h103);
        for (int s = 1; s <= 4; s++) begin
            send_sample(16'(s));
            if (s == 1) begin
                check("t2_short_inData", inData, 16'h0);
                check("t2_short_sign", inCoeffSign, 1'b1);
            end
            if (s == 4) begin
                check("t2_k3_inData", inData, 16'h0001);
                check("t2_k3_sign", inCoeffSign, 1'b1);
                strobe(1'b1, 1'b0);
                check("t2_k0_inData", inData, 16'h0004);
                check("t2_k0_sign", inCoeffSign, 1'b0);
            end
            finish_frame(16);
        end

        // 257 samples with k = 255 then k = 0: write pointer wraps
        apply_reset();
        wr_coeff(9'd0, 9'h0FF);
        wr_coeff(9'd1, 9'h000);
        for (int s = 1; s <= 257; s++) begin
            send_sample(16'(s));
            if (s == 255) check("t3_fill255_inData", inData, 16'h0);
            if (s == 256) check("t3_full_inData", inData, 16'h0001);
            if (s == 257) begin
                check("t3_wrap_inData", inData, 16'h0002);
                strobe(1'b1, 1'b0);
                check("t3_wrap_k0", inData, 16'h0101);
            end
            finish_frame(16);
        end

        // Sample arriving mid-frame is dropped and flags overrun
        apply_reset();
        wr_coeff(9'd1, 9'h001);
        send_sample(16'h1111);
        check("t4_pre_overrun", overrun, 1'b0);
        sampleValid = 1'b1; sampleIn = 16'h2222;
        tick();
        sampleValid = 1'b0;
        check("t4_overrun", overrun, 1'b1);
        check("t4_busy", busy, 1'b1);
        finish_frame(16);
        send_sample(16'h3333);
        check("t4_k255_inData", inData, 16'h0);
        strobe(1'b1, 1'b0);
        check("t4_prev_sample", inData, 16'h1111);
        check("t4_overrun_sticky", overrun, 1'b1);
        finish_frame(16);

        // Reset in the middle of FEED, then a clean frame
        apply_reset();
        wr_coeff(9'd0, 9'h000);
        send_sample(16'h7777);
        strobe(1'b1, 1'b1);
        strobe(1'b1, 1'b1);
        check("t5_pre_endIdx", endCoeffIndex, 10'd3);
        apply_reset();
        check("t5_calcResetN", calcResetN, 1'b1);
        check("t5_inData", inData, 16'h0);
        check("t5_sign", inCoeffSign, 1'b0);
        check("t5_rjIn", rjIn, 16'h0);
        check("t5_endIdx", endCoeffIndex, 10'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_frameDone", frameDone, 1'b0);
        check("t5_overrun", overrun, 1'b0);
        send_sample(16'h5555);
        check("t5_clean_inData", inData, 16'h5555);
        check("t5_clean_endIdx", endCoeffIndex, 10'd1);
        strobe(1'b1, 1'b0);
        check("t5_history_cleared", inData, 16'h0);
        finish_frame(16);

        // Both strobes on the last coefficient of stage 1 (r_1 = 2, r_2 = 3)
        apply_reset();
        wr_rj(4'd0, 16'd2);
        wr_rj(4'd1, 16'd3);
        wr_coeff(9'd0, 9'h000);
        wr_coeff(9'd1, 9'h101);
        wr_coeff(9'd2, 9'h002);
        send_sample(16'h000A);
        finish_frame(16);
        send_sample(16'h000B);
        finish_frame(16);
        send_sample(16'h000C);
        check("t6_inData0", inData, 16'h000C);
        check("t6_endIdx0", endCoeffIndex, 10'd2);
        check("t6_rjIn0", rjIn, 16'd2);
        strobe(1'b1, 1'b0);
        check("t6_inData1", inData, 16'h000B);
        check("t6_sign1", inCoeffSign, 1'b1);
        strobe(1'b1, 1'b1);
        check("t6_inData2", inData, 16'h000A);
        check("t6_sign2", inCoeffSign, 1'b0);
        check("t6_endIdx_both", endCoeffIndex, 10'd5);
        check("t6_rjIn_both", rjIn, 16'd3);
        finish_frame(15);

        // Coefficient pointer saturates at the last table entry
        wr_coeff(9'd510, 9'h001);
        wr_coeff(9'd511, 9'h100);
        send_sample(16'h000D);
        check("t7_inData0", inData, 16'h000D);
        for (int i = 0; i < 510; i++) strobe(1'b1, 1'b0);
        check("t7_entry510", inData, 16'h000C);
        check("t7_entry510_sign", inCoeffSign, 1'b0);
        strobe(1'b1, 1'b0);
        check("t7_entry511", inData, 16'h000D);
        check("t7_entry511_sign", inCoeffSign, 1'b1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
        check("t7_sat_inData", inData, 16'h000D);
        check("t7_sat_sign", inCoeffSign, 1'b1);
        check("t7_sat_endIdx", endCoeffIndex, 10'd2);
        finish_frame(16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
